// File: rtl/tff_toggle_debouncer.sv
// Button conditioner for the T flip-flop: synchronises a bouncy input, qualifies
// each new level for STABLE_CYCLES samples and emits a one-cycle toggle request.
module tff_toggle_debouncer #(
  parameter int STABLE_CYCLES    = 4,
  parameter int CNT_W            = 8,
  parameter int PULSE_ON_RELEASE = 0
) (
  input  logic clk,
  input  logic rst_async,
  input  logic btn_in,
  output logic t_pulse,
  output logic btn_level
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             btn_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      btn_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Any return to the old level while waiting restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      IDLE_LOW: begin
        if (btn_s_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!btn_s_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (btn_s_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          pulse_d = (PULSE_ON_RELEASE != 0);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign t_pulse   = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_tff_toggle_debouncer.sv
// Directed bench: two debouncers (press-only and press+release pulsing) share one
// button and reset, each driving a behavioural T flip-flop.
module tb_tff_toggle_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btnIn = 1'b0;
  logic pulseA, levelA, pulseB, levelB;
  logic qA, qB;

  int checks = 0;
  int failures = 0;

  int   pulsesA, firstA, pulsesB, firstB;
  logic levelSeenA, levelSeenB;

  always #5 clk = ~clk;

  tff_toggle_debouncer #(.STABLE_CYCLES(4), .CNT_W(8), .PULSE_ON_RELEASE(0)) dutA (
    .clk(clk), .rst_async(rst), .btn_in(btnIn), .t_pulse(pulseA), .btn_level(levelA)
  );

  tff_toggle_debouncer #(.STABLE_CYCLES(4), .CNT_W(8), .PULSE_ON_RELEASE(1)) dutB (
    .clk(clk), .rst_async(rst), .btn_in(btnIn), .t_pulse(pulseB), .btn_level(levelB)
  );

  // Downstream T flip-flops, reset by the same asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qA <= 1'b0;
      qB <= 1'b0;
    end else begin
      if (pulseA) qA <= ~qA;
      if (pulseB) qB <= ~qB;
    end
  end

  // Steps n rising edges, sampling 1 ns after each; records pulse count and the
  // 1-based edge index of the first pulse for each instance.
  task automatic run_cycles(input int n);
    pulsesA = 0; firstA = 0; pulsesB = 0; firstB = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (pulseA === 1'b1) begin
        pulsesA++;
        if (firstA == 0) firstA = i;
      end
      if (pulseB === 1'b1) begin
        pulsesB++;
        if (firstB == 0) firstB = i;
      end
      if (levelA === 1'b1) levelSeenA = 1'b1;
      if (levelB === 1'b1) levelSeenB = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pulseA !== 1'b0 || pulseB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulse: got A=%b B=%b, want 0 0", pulseA, pulseB);
    end
    checks++;
    if (levelA !== 1'b0 || levelB !== 1'b0 || qA !== 1'b0 || qB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_level_q: got lvl %b %b q %b %b, want 0 0 0 0", levelA, levelB, qA, qB);
    end
    #9 rst = 1'b0;
    levelSeenA = 1'b0; levelSeenB = 1'b0;
    run_cycles(3);
    checks++;
    if (pulsesA != 0 || pulsesB != 0 || levelSeenA || levelSeenB || qA !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got pulses %0d %0d lvl %b %b qA %b, want 0 0 0 0 0",
               pulsesA, pulsesB, levelSeenA, levelSeenB, qA);
    end
  endtask

  task automatic test_clean_press();
    btnIn = 1'b1;
    run_cycles(20);
    checks++;
    if (pulsesA != 1 || firstA != 6) begin
      failures++;
      $display("[TB] FAIL press_A: got %0d pulses first at %0d, want 1 at 6", pulsesA, firstA);
    end
    checks++;
    if (pulsesB != 1 || firstB != 6) begin
      failures++;
      $display("[TB] FAIL press_B: got %0d pulses first at %0d, want 1 at 6", pulsesB, firstB);
    end
    checks++;
    if (levelA !== 1'b1 || levelB !== 1'b1 || qA !== 1'b1 || qB !== 1'b1) begin
      failures++;
      $display("[TB] FAIL press_state: got lvl %b %b q %b %b, want 1 1 1 1", levelA, levelB, qA, qB);
    end
  endtask

  task automatic test_release(input logic expQA, input logic expQB);
    btnIn = 1'b0;
    run_cycles(10);
    checks++;
    if (pulsesA != 0) begin
      failures++;
      $display("[TB] FAIL release_A: got %0d pulses, want 0", pulsesA);
    end
    checks++;
    if (pulsesB != 1 || firstB != 6) begin
      failures++;
      $display("[TB] FAIL release_B: got %0d pulses first at %0d, want 1 at 6", pulsesB, firstB);
    end
    checks++;
    if (levelA !== 1'b0 || levelB !== 1'b0 || qA !== expQA || qB !== expQB) begin
      failures++;
      $display("[TB] FAIL release_state: got lvl %b %b q %b %b, want 0 0 %b %b",
               levelA, levelB, qA, qB, expQA, expQB);
    end
  endtask

  task automatic test_bounce();
    int bouncePulses;
    bouncePulses = 0;
    for (int i = 0; i < 6; i++) begin
      btnIn = (i % 2 == 0);
      run_cycles(1);
      bouncePulses += pulsesA + pulsesB;
    end
    checks++;
    if (bouncePulses != 0) begin
      failures++;
      $display("[TB] FAIL bounce_quiet: got %0d pulses while bouncing, want 0", bouncePulses);
    end
    btnIn = 1'b1;
    run_cycles(10);
    checks++;
    if (pulsesA != 1 || firstA != 6 || pulsesB != 1 || firstB != 6) begin
      failures++;
      $display("[TB] FAIL bounce_settle: got A %0d@%0d B %0d@%0d, want 1@6 1@6",
               pulsesA, firstA, pulsesB, firstB);
    end
    checks++;
    if (qA !== 1'b0 || qB !== 1'b1 || levelA !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bounce_q: got qA %b qB %b lvl %b, want 0 1 1", qA, qB, levelA);
    end
  endtask

  task automatic test_glitch();
    int total;
    levelSeenA = 1'b0; levelSeenB = 1'b0;
    btnIn = 1'b1;
    run_cycles(2);
    total = pulsesA + pulsesB;
    btnIn = 1'b0;
    run_cycles(12);
    total += pulsesA + pulsesB;
    checks++;
    if (total != 0 || levelSeenA || levelSeenB) begin
      failures++;
      $display("[TB] FAIL glitch: got %0d pulses lvl seen %b %b, want 0 0 0", total, levelSeenA, levelSeenB);
    end
    checks++;
    if (qA !== 1'b0 || qB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_q: got %b %b, want 0 0", qA, qB);
    end
  endtask

  task automatic test_reset_mid_qual();
    btnIn = 1'b1;
    run_cycles(4);
    checks++;
    if (pulsesA != 0 || pulsesB != 0) begin
      failures++;
      $display("[TB] FAIL midq_pre: got %0d %0d pulses before reset, want 0 0", pulsesA, pulsesB);
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    run_cycles(10);
    checks++;
    if (pulsesA != 1 || firstA != 6 || pulsesB != 1 || firstB != 6) begin
      failures++;
      $display("[TB] FAIL midq_post: got A %0d@%0d B %0d@%0d, want 1@6 1@6",
               pulsesA, firstA, pulsesB, firstB);
    end
    checks++;
    if (qA !== 1'b1 || qB !== 1'b1 || levelA !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midq_q: got qA %b qB %b lvl %b, want 1 1 1", qA, qB, levelA);
    end
  endtask

  task automatic test_reset_during_pulse();
    btnIn = 1'b1;
    run_cycles(6);
    checks++;
    if (pulseA !== 1'b1 || pulsesA != 1 || firstA != 6) begin
      failures++;
      $display("[TB] FAIL trunc_pre: got pulse %b count %0d@%0d, want 1 1@6", pulseA, pulsesA, firstA);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pulseA !== 1'b0 || pulseB !== 1'b0 || levelA !== 1'b0 || levelB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_async: got pulse %b %b lvl %b %b, want 0 0 0 0",
               pulseA, pulseB, levelA, levelB);
    end
    #2 rst = 1'b0;
    btnIn = 1'b0;
    run_cycles(10);
    checks++;
    if (pulsesA != 0 || pulsesB != 0 || qA !== 1'b0 || qB !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_after: got pulses %0d %0d q %b %b, want 0 0 0 0", pulsesA, pulsesB, qA, qB);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release(1'b1, 1'b0);
    test_bounce();
    test_release(1'b0, 1'b0);
    test_glitch();
    test_reset_mid_qual();
    test_release(1'b1, 1'b0);
    test_reset_during_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
